fir_output_stage: RTL and testbench

Terminates the systolic FIR chain built from cascaded DSP multiply-add blocks. It accepts the input sample stream, drives the chain's shared enable, and discards chain outputs until the pipeline is primed. Each primed chain result is rounded, shifted and saturated. Results are then delivered through a 2-entry valid/ready output buffer whose backpressure freezes the whole chain.

---
 rtl/fir_output_stage_if.sv | 27 ++
 rtl/fir_output_stage.sv | 118 +++++++++++
 tb/tb_fir_output_stage.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/fir_output_stage_if.sv
// Handshake and chain bundle for the FIR output stage.
// The stage itself connects through the slave view.
interface fir_output_stage_if #(
  parameter int unsigned CHAIN_WIDTH = 40,
  parameter int unsigned OUT_WIDTH   = 18
);
  logic                          s_valid_i;
  logic                          s_ready_o;
  logic                          chain_en_o;
  logic                          chain_clr_o;
  logic signed [CHAIN_WIDTH-1:0] chain_i;
  logic signed [OUT_WIDTH-1:0]   m_data_o;
  logic                          m_valid_o;
  logic                          m_ready_i;
  logic                          sat_o;
  logic                          sat_clr_i;

  modport slave (
    input  s_valid_i, chain_i, m_ready_i, sat_clr_i,
    output s_ready_o, chain_en_o, chain_clr_o, m_data_o, m_valid_o, sat_o
  );

  modport master (
    output s_valid_i, chain_i, m_ready_i, sat_clr_i,
    input  s_ready_o, chain_en_o, chain_clr_o, m_data_o, m_valid_o, sat_o
  );
endinterface

// File: rtl/fir_output_stage.sv
// Output stage of the systolic FIR chain: priming, round/shift/saturate and a
// 2-entry output buffer whose fullness stalls the chain enable.
module fir_output_stage #(
  parameter int unsigned CHAIN_WIDTH  = 40,
  parameter int unsigned OUT_WIDTH    = 18,
  parameter int unsigned SHIFT        = 17,
  parameter int unsigned PIPE_LATENCY = 9
) (
  input logic               clk_i,
  input logic               rst_ni,
  fir_output_stage_if.slave bus
);

  localparam int unsigned EW = CHAIN_WIDTH + 1;
  localparam int unsigned PW = (PIPE_LATENCY > 0) ? $clog2(PIPE_LATENCY + 1) : 1;
  localparam logic [PW-1:0] PRIME_MAX = PW'(PIPE_LATENCY);
  localparam logic signed [EW-1:0] RND =
    (SHIFT > 0) ? (EW'(1) << (SHIFT - 1)) : '0;
  localparam logic signed [EW-1:0] SAT_MAX =
    EW'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
  localparam logic signed [EW-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic {
    PRIMING,
    RUNNING
  } phase_e;

  phase_e                       phase;
  logic [PW-1:0]                prime;
  logic [1:0]                   occ;
  logic                         wr_ptr;
  logic                         rd_ptr;
  logic signed [OUT_WIDTH-1:0]  mem [2];
  logic                         sat;

  logic                         ready;
  logic                         chain_en;
  logic                         push;
  logic                         pop;

  logic signed [EW-1:0]         ext;
  logic signed [EW-1:0]         rounded;
  logic signed [EW-1:0]         shifted;
  logic signed [OUT_WIDTH-1:0]  result;
  logic                         clamped;

  // Ready never looks at m_ready_i, so downstream cannot form a loop into the chain.
  assign ready    = rst_ni & (occ != 2'd2);
  assign chain_en = bus.s_valid_i & ready;
  assign phase    = (prime == PRIME_MAX) ? RUNNING : PRIMING;
  assign push     = chain_en & (phase == RUNNING);
  assign pop      = (occ != 2'd0) & bus.m_ready_i;

  assign bus.s_ready_o   = ready;
  assign bus.chain_en_o  = chain_en;
  assign bus.chain_clr_o = ~rst_ni;
  assign bus.m_valid_o   = (occ != 2'd0);
  assign bus.m_data_o    = mem[rd_ptr];
  assign bus.sat_o       = sat;

  always_comb begin
    ext     = {bus.chain_i[CHAIN_WIDTH-1], bus.chain_i};
    rounded = ext + RND;
    shifted = rounded >>> SHIFT;
    clamped = 1'b0;
    result  = shifted[OUT_WIDTH-1:0];
    if (shifted > SAT_MAX) begin
      result  = SAT_MAX[OUT_WIDTH-1:0];
      clamped = 1'b1;
    end else if (shifted < SAT_MIN) begin
      result  = SAT_MIN[OUT_WIDTH-1:0];
      clamped = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prime <= '0;
    end else if (chain_en && (phase == PRIMING)) begin
      prime <= prime + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      occ    <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= result;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // A clamped push outranks a same-cycle clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sat <= 1'b0;
    end else if (push && clamped) begin
      sat <= 1'b1;
    end else if (bus.sat_clr_i) begin
      sat <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_output_stage.sv
// Directed bench for fir_output_stage (SHIFT=4, OUT_WIDTH=8, PIPE_LATENCY=9)
// with a queue scoreboard for buffer ordering.
module tb_fir_output_stage;

  localparam int unsigned CW = 40;
  localparam int unsigned OW = 8;
  localparam int unsigned PL = 9;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  int   prime_m;
  bit   sat_m;
  int   q[$];

  fir_output_stage_if #(.CHAIN_WIDTH(CW), .OUT_WIDTH(OW)) bus ();

  fir_output_stage #(
    .CHAIN_WIDTH (CW),
    .OUT_WIDTH   (OW),
    .SHIFT       (4),
    .PIPE_LATENCY(PL)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_val(input int c, output bit clamped);
    longint v;
    v = (longint'(c) + 64'sd8) >>> 4;
    clamped = 1'b0;
    if (v > 127) begin
      v = 127;
      clamped = 1'b1;
    end else if (v < -128) begin
      v = -128;
      clamped = 1'b1;
    end
    return int'(v);
  endfunction

  // One clock cycle starting at posedge+1; exp_val/exp_clamp describe the
  // result if this cycle turns out to push.
  task automatic cycle(input int c, input bit v, input bit r, input bit clr,
                       input int exp_val, input bit exp_clamp);
    bit rdy_e, acc, psh, pp;
    bus.chain_i   = CW'(c);
    bus.s_valid_i = v;
    bus.m_ready_i = r;
    bus.sat_clr_i = clr;
    #1;
    rdy_e = (q.size() != 2);
    check("s_ready", longint'(bus.s_ready_o), longint'(rdy_e));
    check("chain_en", longint'(bus.chain_en_o), longint'(v & rdy_e));
    check("m_valid", longint'(bus.m_valid_o), longint'(q.size() != 0));
    if (q.size() != 0) check("m_data", longint'(bus.m_data_o), longint'(q[0]));
    acc = v & rdy_e;
    psh = acc && (prime_m == PL);
    pp  = (q.size() != 0) && r;
    if (acc && prime_m < PL) prime_m++;
    if (psh && exp_clamp) sat_m = 1'b1;
    else if (clr) sat_m = 1'b0;
    @(posedge clk);
    #1;
    if (pp) void'(q.pop_front());
    if (psh) q.push_back(exp_val);
    check("sat", longint'(bus.sat_o), longint'(sat_m));
  endtask

  task automatic prime_run(input int base);
    for (int i = 0; i < int'(PL); i++) begin
      cycle(base + 160 * (i + 1), 1'b1, 1'b1, 1'b0, 0, 1'b0);
      check("primed_silent", longint'(bus.m_valid_o), 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  val;
    bit  clp;
    int  c;
    tests   = 0;
    fails   = 0;
    prime_m = 0;
    sat_m   = 1'b0;

    rst_n         = 1'b0;
    bus.s_valid_i = 1'b1;
    bus.m_ready_i = 1'b0;
    bus.sat_clr_i = 1'b0;
    bus.chain_i   = '0;
    #3;
    check("rst_s_ready", longint'(bus.s_ready_o), 0);
    check("rst_chain_en", longint'(bus.chain_en_o), 0);
    check("rst_chain_clr", longint'(bus.chain_clr_o), 1);
    check("rst_m_valid", longint'(bus.m_valid_o), 0);
    check("rst_m_data", longint'(bus.m_data_o), 0);
    check("rst_sat", longint'(bus.sat_o), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("run_chain_clr", longint'(bus.chain_clr_o), 0);

    // Priming: nine accepted samples produce nothing, the tenth does.
    prime_run(0);
    cycle(24, 1'b1, 1'b1, 1'b0, 2, 1'b0);
    check("first_out_valid", longint'(bus.m_valid_o), 1);
    check("first_out_data", longint'(bus.m_data_o), 2);

    // Rounding.
    cycle(-24, 1'b1, 1'b1, 1'b0, -1, 1'b0);
    cycle(7,   1'b1, 1'b1, 1'b0,  0, 1'b0);
    cycle(8,   1'b1, 1'b1, 1'b0,  1, 1'b0);
    cycle(8,   1'b0, 1'b1, 1'b0,  0, 1'b0);
    check("no_sat_yet", longint'(bus.sat_o), 0);

    // Saturation and sticky flag.
    cycle(5000,  1'b1, 1'b1, 1'b0,  127, 1'b1);
    check("sat_hi_data", longint'(bus.m_data_o), 127);
    cycle(0,     1'b0, 1'b1, 1'b1,    0, 1'b0);
    check("sat_cleared", longint'(bus.sat_o), 0);
    cycle(-5000, 1'b1, 1'b1, 1'b1, -128, 1'b1);
    check("sat_set_wins", longint'(bus.sat_o), 1);
    check("sat_lo_data", longint'(bus.m_data_o), -128);
    cycle(0,     1'b0, 1'b1, 1'b1,    0, 1'b0);
    cycle(0,     1'b0, 1'b1, 1'b0,    0, 1'b0);

    // Backpressure: A, B held; further chain values ignored.
    cycle(160, 1'b1, 1'b0, 1'b0, 10, 1'b0);
    cycle(320, 1'b1, 1'b0, 1'b0, 20, 1'b0);
    cycle(480, 1'b1, 1'b0, 1'b0, 30, 1'b0);
    check("bp_ready_low", longint'(bus.s_ready_o), 0);
    check("bp_head_a", longint'(bus.m_data_o), 10);
    cycle(-999, 1'b1, 1'b0, 1'b0, -62, 1'b0);
    cycle(640,  1'b1, 1'b1, 1'b0,  40, 1'b0);
    check("bp_head_b", longint'(bus.m_data_o), 20);
    cycle(640,  1'b1, 1'b1, 1'b0,  40, 1'b0);
    cycle(800,  1'b1, 1'b1, 1'b0,  50, 1'b0);
    cycle(0,    1'b0, 1'b1, 1'b0,   0, 1'b0);
    cycle(0,    1'b0, 1'b1, 1'b0,   0, 1'b0);
    check("bp_drained", longint'(bus.m_valid_o), 0);

    // Streaming random samples at one per cycle.
    for (int i = 0; i < 100; i++) begin
      c   = int'($urandom_range(6000, 0)) - 3000;
      val = ref_val(c, clp);
      cycle(c, 1'b1, 1'b1, 1'b0, val, clp);
    end
    cycle(0, 1'b0, 1'b1, 1'b1, 0, 1'b0);
    cycle(0, 1'b0, 1'b1, 1'b0, 0, 1'b0);

    // Reset mid-stream with a full buffer.
    cycle(160, 1'b1, 1'b0, 1'b0, 10, 1'b0);
    cycle(320, 1'b1, 1'b0, 1'b0, 20, 1'b0);
    check("full_before_rst", longint'(bus.s_ready_o), 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_m_valid", longint'(bus.m_valid_o), 0);
    check("mid_rst_s_ready", longint'(bus.s_ready_o), 0);
    check("mid_rst_chain_clr", longint'(bus.chain_clr_o), 1);
    check("mid_rst_chain_en", longint'(bus.chain_en_o), 0);
    q.delete();
    prime_m = 0;
    sat_m   = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    prime_run(16);
    cycle(8, 1'b1, 1'b1, 1'b0, 1, 1'b0);
    check("reprime_out_valid", longint'(bus.m_valid_o), 1);
    check("reprime_out_data", longint'(bus.m_data_o), 1);
    cycle(0, 1'b0, 1'b1, 1'b0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
